inst_rom_responder: RTL

//  Instruction-memory responder for the CPU's instruction fetch port (rom_ce/rom_addr -> rom_data).

---
 rtl/inst_rom_responder_pkg.sv | 37 +++
 rtl/inst_rom_responder_byte_packer.sv | 51 +++++
 rtl/inst_rom_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/inst_rom_responder_pkg.sv
// Shared definitions for the instruction ROM responder.
// Holds the bus widths, the constant values used on the fetch port,
// the RUN/LOAD state type and a helper that drops a load byte into its
// big-endian lane of a 32-bit word.
package inst_rom_responder_pkg;

  localparam int InstAddrBus    = 32;
  localparam int InstBus        = 32;
  localparam int RomLoadByteBus = 8;

  localparam logic [InstBus-1:0] ZeroWord    = '0;
  localparam logic               ChipEnable  = 1'b1;
  localparam logic               ChipDisable = 1'b0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } rom_state_t;

  // Slot 0 is the first byte of a group and lands in [31:24] (MIPS order).
  function automatic logic [InstBus-1:0] place_byte(
    input logic [InstBus-1:0]        acc,
    input logic [1:0]                slot,
    input logic [RomLoadByteBus-1:0] data_byte
  );
    logic [InstBus-1:0] lane;
    lane = ZeroWord;
    case (slot)
      2'd0:    lane = {data_byte, 24'h000000};
      2'd1:    lane = {8'h00, data_byte, 16'h0000};
      2'd2:    lane = {16'h0000, data_byte, 8'h00};
      default: lane = {24'h000000, data_byte};
    endcase
    return acc | lane;
  endfunction

endpackage

// File: rtl/inst_rom_responder_byte_packer.sv
// Byte-to-word packer for the ROM load stream.
// Collects bytes big-endian into a 32-bit word. The assembled word is
// presented combinationally together with word_valid on the cycle of the
// 4th byte, or on an earlier byte when flush is high (low lanes zero).
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear       discard any partially collected word
//   byte_valid  data_byte is consumed this cycle
//   data_byte   incoming byte
//   flush       close the word with this byte, zero-filling the rest
//   word        assembled word (valid only with word_valid)
//   word_valid  word is complete this cycle
module inst_rom_responder_byte_packer
  import inst_rom_responder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      byte_valid,
  input  logic [RomLoadByteBus-1:0] data_byte,
  input  logic                      flush,
  output logic [InstBus-1:0]        word,
  output logic                      word_valid
);

  logic [InstBus-1:0] acc_reg;
  logic [1:0]         slot_reg;
  logic [InstBus-1:0] merged;

  // acc_reg only ever holds already-placed lanes; untouched lanes stay
  // zero, which gives the zero-fill on flush for free.
  assign merged     = place_byte(acc_reg, slot_reg, data_byte);
  assign word       = merged;
  assign word_valid = byte_valid && ((slot_reg == 2'd3) || flush);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg  <= ZeroWord;
      slot_reg <= 2'd0;
    end else if (byte_valid) begin
      if (word_valid) begin
        acc_reg  <= ZeroWord;
        slot_reg <= 2'd0;
      end else begin
        acc_reg  <= merged;
        slot_reg <= slot_reg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_rom_responder.sv
// Instruction-memory responder for the CPU fetch port.
// A word-addressed store answers fetches combinationally; it is filled at
// run time from a byte-wide load stream packed big-endian into words.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rom_ce_i, rom_addr_i     fetch enable and byte address (PC)
//   rom_data_o               fetched instruction, 0 when disabled,
//                            loading or out of range
//   addr_err_o               sticky out-of-range fetch flag
//   load_start_i             enter/restart LOAD with pointer 0
//   load_valid_i/byte_i/last_i, load_ready_o   load byte handshake
//   loading_o                1 while in LOAD
//   load_count_o             words written by current/last load
//   load_ovf_o               sticky: bytes arrived with the store full
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int                     ADDR_W = 10,
  parameter logic [InstAddrBus-1:0] BASE   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rom_ce_i,
  input  logic [InstAddrBus-1:0]    rom_addr_i,
  output logic [InstBus-1:0]        rom_data_o,
  output logic                      addr_err_o,
  input  logic                      load_start_i,
  input  logic                      load_valid_i,
  input  logic [RomLoadByteBus-1:0] load_byte_i,
  input  logic                      load_last_i,
  output logic                      load_ready_o,
  output logic                      loading_o,
  output logic [ADDR_W:0]           load_count_o,
  output logic                      load_ovf_o
);

  localparam int          DEPTH = 2 ** ADDR_W;
  localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

  rom_state_t         state_reg;
  logic [ADDR_W:0]    ptr_reg;
  logic               ovf_reg;
  logic               err_reg;
  logic [InstBus-1:0] mem [DEPTH];

  logic [InstAddrBus-1:0] offset;
  logic                   in_range;
  logic                   store_full;
  logic                   byte_accept;
  logic [InstBus-1:0]     pack_word;
  logic                   pack_valid;

  // Addresses below BASE wrap to huge offsets and fall out of range too.
  assign offset   = rom_addr_i - BASE;
  assign in_range = ({1'b0, offset} < SPAN);

  // The pointer never passes DEPTH, so its MSB alone marks "full".
  assign store_full  = ptr_reg[ADDR_W];
  assign byte_accept = (state_reg == ST_LOAD) && load_valid_i && !load_start_i && !rst;

  // Bytes arriving with the store full are accepted but never reach the
  // packer; the packer is always empty at that point.
  inst_rom_responder_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start_i),
    .byte_valid (byte_accept && !store_full),
    .data_byte  (load_byte_i),
    .flush      (load_last_i),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

  // Store: synchronous write, asynchronous read; never cleared by reset.
  always_ff @(posedge clk) begin
    if (pack_valid) begin
      mem[ptr_reg[ADDR_W-1:0]] <= pack_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      ptr_reg   <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if ((rom_ce_i != ChipDisable) && !in_range) begin
        err_reg <= 1'b1;
      end
      if (load_start_i) begin
        state_reg <= ST_LOAD;
        ptr_reg   <= '0;
        ovf_reg   <= 1'b0;
      end else if (byte_accept) begin
        if (store_full) begin
          ovf_reg <= 1'b1;
        end else if (pack_valid) begin
          ptr_reg <= ptr_reg + 1'b1;
        end
        if (load_last_i) begin
          state_reg <= ST_RUN;
        end
      end
    end
  end

  assign loading_o    = (state_reg == ST_LOAD);
  assign load_ready_o = loading_o;
  assign load_count_o = ptr_reg;
  assign load_ovf_o   = ovf_reg;
  assign addr_err_o   = err_reg;

  // While loading the CPU sees a NOP (all zeros) rather than a half-written image.
  assign rom_data_o = ((rom_ce_i == ChipEnable) && (state_reg == ST_RUN) && in_range)
                      ? mem[offset[ADDR_W+1:2]] : ZeroWord;

endmodule
